// File: rtl/io_seq_if.sv
// Operator/CPU-facing signal bundle for the io_seq handshake sequencer.
// The slave side is the sequencer itself; the master side drives switches, button and CPU strobes.
interface io_seq_if #(
  parameter int N          = 8,
  parameter int NUM_READS  = 2,
  parameter int NUM_WRITES = 2
);
  localparam int RW = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int WW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;

  logic          handshake;
  logic          write_out;
  logic [N-1:0]  in;
  logic [N-1:0]  cpu_out;
  logic [N-1:0]  cpu_in;
  logic [N-1:0]  out;
  logic          halt_program;
  logic [RW-1:0] rd_idx;
  logic [WW-1:0] wr_idx;
  logic          frame_done;

  modport slave (
    input  handshake, write_out, in, cpu_out,
    output cpu_in, out, halt_program, rd_idx, wr_idx, frame_done
  );

  modport master (
    output handshake, write_out, in, cpu_out,
    input  cpu_in, out, halt_program, rd_idx, wr_idx, frame_done
  );
endinterface

// File: rtl/io_seq.sv
// Handshake-driven I/O sequencer: gathers a frame of switch words for the CPU, then
// presents CPU results on the LEDs one by one, stalling the CPU while the operator acts.
module io_seq #(
  parameter int N           = 8,
  parameter int NUM_READS   = 2,
  parameter int NUM_WRITES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     n_reset,
  io_seq_if.slave  bus
);
  localparam int RW = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int WW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(NUM_READS - 1);
  localparam logic [WW-1:0] WR_LAST = WW'(NUM_WRITES - 1);

  typedef enum logic [2:0] {
    POLL_RD = 3'd0,
    RD      = 3'd1,
    RD_REL  = 3'd2,
    POLL_WR = 3'd3,
    WR_HOLD = 3'd4,
    WR_REL  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [RW-1:0]          rd_idx_q, rd_idx_d;
  logic [WW-1:0]          wr_idx_q, wr_idx_d;
  logic [N-1:0]           out_q, out_d;
  logic                   frame_done_q, frame_done_d;
  logic                   hs_s;

  // The button is asynchronous; only the last synchroniser stage is trusted.
  assign hs_s   = sync_q[SYNC_STAGES-1];
  assign sync_d = SYNC_STAGES'({sync_q, bus.handshake});

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= POLL_RD;
      sync_q       <= '0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      out_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rd_idx_d         = rd_idx_q;
    wr_idx_d         = wr_idx_q;
    out_d            = out_q;
    frame_done_d     = 1'b0;
    bus.cpu_in       = '0;
    bus.halt_program = 1'b1;
    unique case (state_q)
      POLL_RD: if (hs_s) state_d = RD;
      RD: begin
        bus.cpu_in       = bus.in;
        bus.halt_program = 1'b0;
        state_d          = RD_REL;
      end
      // Waiting for release makes a long press count as a single read.
      RD_REL: if (!hs_s) begin
        if (rd_idx_q == RD_LAST) begin
          rd_idx_d = '0;
          wr_idx_d = '0;
          state_d  = POLL_WR;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = POLL_RD;
        end
      end
      POLL_WR: begin
        bus.halt_program = 1'b0;
        if (bus.write_out) begin
          out_d   = bus.cpu_out;
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: if (hs_s) state_d = WR_REL;
      WR_REL: if (!hs_s) begin
        if (wr_idx_q == WR_LAST) begin
          wr_idx_d     = '0;
          frame_done_d = 1'b1;
          state_d      = POLL_RD;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
          state_d  = POLL_WR;
        end
      end
      default: state_d = POLL_RD;
    endcase
  end

  assign bus.out        = out_q;
  assign bus.rd_idx     = rd_idx_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: doc/io_seq.md
Name: io_seq

Overview:
Parametrised handshake I/O sequencer for the pico-MIPS top level.
- Collects a frame of NUM_READS input words from switches, each qualified by an external handshake, and presents each word to the CPU for exactly one cycle.
- Then accepts NUM_WRITES result words from the CPU and holds each on the output until the operator acknowledges it with a handshake pulse.
- Stalls the CPU through halt_program whenever it is waiting on the operator.
- Adds a handshake synchroniser, word indices and a frame-done pulse.

Parameters:
N, 8, data width of in/out/cpu_in/cpu_out
NUM_READS, 2, input words per frame (>=1)
NUM_WRITES, 2, output words per frame (>=1)
SYNC_STAGES, 2, flip-flops in handshake synchroniser (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
n_reset  input  1  asynchronous active-low reset
handshake  input  1  asynchronous operator handshake (button), active high
write_out  input  1  CPU strobe: cpu_out is valid this cycle
in  input  N  external input word (switches)
cpu_out  input  N  word written by CPU
cpu_in  output  N  word presented to CPU, combinational
out  output  N  registered output word (LEDs)
halt_program  output  1  1 = CPU must stall, combinational
rd_idx  output  max(1,$clog2(NUM_READS))  index of current read word
wr_idx  output  max(1,$clog2(NUM_WRITES))  index of current write word
frame_done  output  1  registered one-cycle pulse after final write released

Behaviour:
- Reset (n_reset=0, async, any state):
  - state=POLL_RD; rd_idx=0; wr_idx=0; out=0; frame_done=0; all synchroniser flops=0.
  - Takes effect immediately, including mid-frame; no partial-frame state survives.
- Synchroniser: hs_s is handshake delayed through SYNC_STAGES flops. The FSM uses only hs_s, never raw handshake.
- Default combinational values, overridden per state: cpu_in=0, halt_program=1.
- States and transitions (transitions on rising clk):
  - POLL_RD: wait; hs_s=1 -> RD.
  - RD: exactly one cycle. cpu_in=in, halt_program=0. -> RD_REL unconditionally.
  - RD_REL: wait hs_s=0.
    - If rd_idx==NUM_READS-1: rd_idx<=0, wr_idx<=0, -> POLL_WR.
    - Else: rd_idx<=rd_idx+1, -> POLL_RD.
  - POLL_WR: halt_program=0. On write_out=1: out<=cpu_out, -> WR_HOLD.
  - WR_HOLD: out held; wait hs_s=1 -> WR_REL.
  - WR_REL: out held; wait hs_s=0.
    - If wr_idx==NUM_WRITES-1: wr_idx<=0, frame_done<=1 for one cycle, -> POLL_RD.
    - Else: wr_idx<=wr_idx+1, -> POLL_WR.
- write_out is ignored in every state except POLL_WR. out changes only on reset or on the POLL_WR->WR_HOLD edge.
- One read per handshake pulse: a handshake held high yields exactly one RD cycle, regardless of how long it is held.
- A handshake pulse shorter than one clock may be missed. No glitch filtering is provided.
- Read latency: a handshake rising before edge k gives hs_s=1 after SYNC_STAGES edges. RD is active in the cycle after that; cpu_in is valid during that single cycle.
- Simultaneous write_out and handshake in POLL_WR: the write is taken. The handshake only counts once it is seen in WR_HOLD.
- Indices never exceed NUM_*-1 and wrap to 0 at frame end. NUM_READS=1 or NUM_WRITES=1: the index stays 0.
- Illegal or unreachable state encoding: recover to POLL_RD.

Test Plan:
- Reset: assert n_reset=0 mid-WR_HOLD with out=8'hA5 -> same cycle out=0, halt_program=1, rd_idx=0, wr_idx=0; after release, FSM is in POLL_RD.
- Two reads (N=8, defaults): in=8'h12, pulse handshake 5 cycles; in=8'h34, pulse again -> exactly two single cycles with halt_program=0. cpu_in=8'h12 with rd_idx=0, then 8'h34 with rd_idx=1. Each RD cycle lands SYNC_STAGES+1 edges after the handshake rise.
- Long press: handshake held high 50 cycles -> exactly one RD cycle; rd_idx advances only after release.
- Writes: in POLL_WR, drive write_out with cpu_out=8'h46 -> out=8'h46 next edge, halt_program=1. A later write_out with 8'hFF while in WR_HOLD leaves out=8'h46. A handshake pulse advances to wr_idx=1 and halt_program=0.
- Frame wrap: complete both writes (second word 8'h07) -> frame_done high one cycle on release of the second handshake. Then rd_idx=0, wr_idx=0, state POLL_RD, out stays 8'h07.
- Parameter sweep NUM_READS=3, NUM_WRITES=1, SYNC_STAGES=3 -> three RD cycles, then one write per frame. The read latency becomes 4 edges.
